// File: rtl/uart_bridge_pkg.sv
// Shared constants and types for the UART-to-bus bridge: protocol byte codes,
// parser state encoding and the RX/TX oversample ratio.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] RSP_OK = 8'h4B;

  localparam int OVS = 16;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_bus_bridge_if.sv
// Single-transaction req/ack core bus driven by the bridge (master) towards
// the register fabric (slave).
interface uart_bus_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/uart_bridge_phy.sv
// 8N1 UART physical layer: fractional baud accumulator producing a 16x tick,
// synchronised RX deserialiser (valid pulse) and TX serialiser (valid/ready).
module uart_bridge_phy
  import uart_bridge_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready
);

  localparam int               ACC_W = $clog2(CLK_FREQ + BAUD * OVS);
  localparam logic [ACC_W-1:0] INC   = ACC_W'(BAUD * OVS);
  localparam logic [ACC_W-1:0] LIM   = ACC_W'(CLK_FREQ);

  logic [ACC_W-1:0] acc, acc_sum;
  logic             tick;

  assign acc_sum = acc + INC;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (acc_sum >= LIM) begin
      acc  <= acc_sum - LIM;
      tick <= 1'b1;
    end else begin
      acc  <= acc_sum;
      tick <= 1'b0;
    end

  // RX: rx_bit 0 = start, 1..8 = data, 9 = stop; sample on the 8th tick of each bit
  logic [1:0] rx_sync;
  logic       rx_s, rx_prev, rx_busy;
  logic [3:0] rx_tcnt, rx_bit;
  logic [7:0] rx_sh;

  assign rx_s    = rx_sync[1];
  assign rx_data = rx_sh;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_sync   <= 2'b11;
      rx_prev   <= 1'b1;
      rx_busy   <= 1'b0;
      rx_tcnt   <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[0], uart_rx};
      rx_prev   <= rx_s;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_s) begin
          rx_busy <= 1'b1;
          rx_tcnt <= '0;
          rx_bit  <= '0;
        end
      end else if (tick) begin
        rx_tcnt <= rx_tcnt + 4'd1;
        if (rx_tcnt == 4'd7) begin
          rx_bit <= rx_bit + 4'd1;
          if (rx_bit == 4'd0) begin
            if (rx_s) rx_busy <= 1'b0;
          end else if (rx_bit == 4'd9) begin
            rx_busy <= 1'b0;
            if (rx_s) rx_valid  <= 1'b1;
            else      frame_err <= 1'b1;
          end else begin
            rx_sh <= {rx_s, rx_sh[7:1]};
          end
        end
      end
    end

  // TX: one-byte holding register lets the next frame follow the stop bit directly
  logic [9:0] tx_sh;
  logic       tx_busy, tx_hold_v;
  logic [3:0] tx_tcnt, tx_bit;
  logic [7:0] tx_hold;

  assign tx_ready = !tx_hold_v;
  assign uart_tx  = tx_sh[0];

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_sh     <= '1;
      tx_busy   <= 1'b0;
      tx_tcnt   <= '0;
      tx_bit    <= '0;
      tx_hold   <= '0;
      tx_hold_v <= 1'b0;
    end else begin
      if (tx_valid && tx_ready) begin
        tx_hold   <= tx_data;
        tx_hold_v <= 1'b1;
      end
      if (tick) begin
        if (!tx_busy || (tx_tcnt == 4'd15 && tx_bit == 4'd9)) begin
          if (tx_hold_v) begin
            tx_sh     <= {1'b1, tx_hold, 1'b0};
            tx_busy   <= 1'b1;
            tx_tcnt   <= '0;
            tx_bit    <= '0;
            tx_hold_v <= 1'b0;
          end else begin
            tx_sh   <= '1;
            tx_busy <= 1'b0;
          end
        end else begin
          tx_tcnt <= tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            tx_sh  <= {1'b1, tx_sh[9:1]};
            tx_bit <= tx_bit + 4'd1;
          end
        end
      end
    end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART-to-bus bridge top: binary W/R command parser driving one req/ack bus
// transaction per command. Define UART_BRIDGE_TIMEOUT_EN to abandon stalled commands.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int CLK_FREQ    = 100000000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_rx,
  output logic                uart_tx,
  uart_bus_bridge_if.master   bus,
  output logic                frame_err,
  output logic                timeout
);

  localparam int NA    = ADDR_W / 8;
  localparam int ND    = DATA_W / 8;
  localparam int CNT_W = $clog2(max2(NA, ND)) + 1;

  logic       rx_valid, tx_valid, tx_ready, hs;
  logic [7:0] rx_data, tx_data;

  uart_bridge_phy #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_phy (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .frame_err(frame_err),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  state_e            state;
  logic [CNT_W-1:0]  cnt, last;
  logic              is_wr;
  logic [DATA_W-1:0] resp;

  // response bytes leave MSB first from the top of the shift register
  assign tx_valid = (state == RESP);
  assign tx_data  = resp[DATA_W-1 -: 8];
  assign hs       = tx_valid && tx_ready;
  assign last     = is_wr ? '0 : CNT_W'(ND - 1);

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_wr     <= 1'b0;
      resp      <= '0;
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.wdata <= '0;
`ifdef UART_BRIDGE_TIMEOUT_EN
      to_cnt    <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
`ifdef UART_BRIDGE_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE:
          if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
            is_wr <= (rx_data == CMD_WR);
            state <= ADDR;
            cnt   <= '0;
          end
        ADDR:
          if (rx_valid) begin
            bus.addr <= (bus.addr << 8) | ADDR_W'(rx_data);
            cnt      <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(NA - 1)) begin
              cnt <= '0;
              if (is_wr) state <= WDATA;
              else begin
                state   <= BUS;
                bus.req <= 1'b1;
                bus.we  <= 1'b0;
              end
            end
          end
        WDATA:
          if (rx_valid) begin
            bus.wdata <= (bus.wdata << 8) | DATA_W'(rx_data);
            cnt       <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(ND - 1)) begin
              cnt     <= '0;
              state   <= BUS;
              bus.req <= 1'b1;
              bus.we  <= 1'b1;
            end
          end
        BUS:
          if (bus.ack && bus.req) begin
            bus.req <= 1'b0;
            bus.we  <= 1'b0;
            resp    <= is_wr ? (DATA_W'(RSP_OK) << (DATA_W - 8)) : bus.rdata;
            state   <= RESP;
            cnt     <= '0;
          end
        RESP:
          if (hs) begin
            resp <= resp << 8;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == last) begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
        default: state <= IDLE;
      endcase
`ifdef UART_BRIDGE_TIMEOUT_EN
      // a received byte reloads the counter, so it wins over a same-cycle expiry
      if (state == IDLE) begin
        to_cnt <= TO_W'(TIMEOUT_CYC);
      end else if (state == ADDR || state == WDATA) begin
        if (rx_valid) to_cnt <= TO_W'(TIMEOUT_CYC);
        else if (to_cnt == '0) begin
          state   <= IDLE;
          cnt     <= '0;
          timeout <= 1'b1;
        end else to_cnt <= to_cnt - TO_W'(1);
      end
`endif
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Randomised self-checking bench: drives UART commands, models the bus side and
// decodes the TX line, comparing against a command-level reference model.
`timescale 1ns/1ps
module tb_uart_bus_bridge;

  localparam int  CLK_FREQ    = 10_000_000;
  localparam int  BAUD        = 115200;
  localparam int  ADDR_W      = 16;
  localparam int  DATA_W      = 32;
  localparam int  TIMEOUT_CYC = 1000;
  localparam int  NA          = ADDR_W / 8;
  localparam int  ND          = DATA_W / 8;
  localparam real BIT_NS      = 1.0e9 / BAUD;

  logic clk = 1'b0, rst = 1'b0, uart_rx = 1'b1;
  logic uart_tx, frame_err, timeout;

  uart_bus_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  uart_bus_bridge #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .bus(bus), .frame_err(frame_err), .timeout(timeout)
  );

  always #50 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int fe_pulses = 0, to_pulses = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (frame_err) fe_pulses <= fe_pulses + 1;
    if (timeout)   to_pulses <= to_pulses + 1;
  end

  // TX line decoder: mid-bit sampling at the nominal bit time
  logic [7:0] txq[$];
  real        tst[$];
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge uart_tx);
      if (!rst) continue;
      tst.push_back($realtime);
      #(BIT_NS / 2);
      chk("tx_start_bit", uart_tx, 1'b0);
      for (int i = 0; i < 8; i++) begin
        #(BIT_NS);
        b[i] = uart_tx;
      end
      #(BIT_NS);
      chk("tx_stop_bit", uart_tx, 1'b1);
      txq.push_back(b);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      #(BIT_NS);
    end
    uart_rx = stop;
    #(BIT_NS);
    uart_rx = 1'b1;
    if (!stop) #(BIT_NS);
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    @(posedge clk); #1;
    while (!bus.req && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    ok = bus.req;
  endtask

  task automatic serve(input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input int dly);
    bit ok;
    wait_req(ok);
    chk("req_seen", ok, 1'b1);
    if (!ok) return;
    chk("req_we", bus.we, wr);
    chk("req_addr", bus.addr, a);
    if (wr) chk("req_wdata", bus.wdata, d);
    repeat (dly) begin @(posedge clk); #1; end
    chk("ack_req_held", bus.req, 1'b1);
    chk("ack_we_held", bus.we, wr);
    chk("ack_addr_held", bus.addr, a);
    if (wr) chk("ack_wdata_held", bus.wdata, d);
    bus.ack   = 1'b1;
    bus.rdata = wr ? DATA_W'($urandom) : d;
    @(posedge clk); #1;
    bus.ack   = 1'b0;
    bus.rdata = DATA_W'($urandom);
    chk("req_fall", bus.req, 1'b0);
  endtask

  task automatic wait_rsp(input int cnt);
    int n = 0;
    while (txq.size() < cnt && n < 1200 * cnt + 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("rsp_count", txq.size(), cnt);
  endtask

  // reference model: write -> one 'K'; read -> rdata bytes MSB first
  task automatic do_txn(input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input int dly);
    logic [7:0] exp_q[$];
    txq.delete();
    tst.delete();
    if (wr) exp_q.push_back(8'h4B);
    else for (int i = 0; i < ND; i++) exp_q.push_back(8'((d >> (8 * (ND - 1 - i))) & 'hFF));
    send_byte(wr ? 8'h57 : 8'h52, 1'b1);
    for (int i = 0; i < NA; i++) send_byte(8'(a >> (8 * (NA - 1 - i))), 1'b1);
    if (wr) for (int i = 0; i < ND; i++) send_byte(8'(d >> (8 * (ND - 1 - i))), 1'b1);
    serve(wr, a, d, dly);
    wait_rsp(exp_q.size());
    foreach (exp_q[i]) if (i < txq.size()) chk("rsp_byte", txq[i], exp_q[i]);
  endtask

  initial begin
    #9_800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    real span;
    bit  ok;
    int  fe0;
    bus.ack   = 1'b0;
    bus.rdata = '0;

    repeat (5) @(posedge clk);
    #1;
    chk("rst_uart_tx", uart_tx, 1'b1);
    chk("rst_req", bus.req, 1'b0);
    chk("rst_we", bus.we, 1'b0);
    chk("rst_addr", bus.addr, '0);
    chk("rst_wdata", bus.wdata, '0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // stray ack with no request must be ignored
    bus.ack = 1'b1;
    @(posedge clk); #1;
    bus.ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_ack_req", bus.req, 1'b0);

    do_txn(1'b1, 16'h1234, 32'hDEADBEEF, 5);

    do_txn(1'b0, 16'h0010, 32'hCAFEF00D, 2);
    span = (tst.size() == ND) ? tst[ND-1] - tst[0] : 0.0;
    chk("baud_span_2pct", (span > 0.98 * 30.0 * BIT_NS) && (span < 1.02 * 30.0 * BIT_NS), 1'b1);

    // framing error on a command-valued byte, then an unknown command byte
    fe0 = fe_pulses;
    send_byte(8'h52, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("frame_err_pulse", fe_pulses - fe0, 1);
    chk("frame_err_no_req", bus.req, 1'b0);
    send_byte(8'h00, 1'b1);
    do_txn(1'b0, 16'hA55A, 32'h0123_4567, 0);

    for (int k = 0; k < 3; k++) begin
      ra = ADDR_W'($urandom);
      rd = DATA_W'($urandom);
      do_txn(1'($urandom_range(0, 1)), ra, rd, $urandom_range(0, 8));
    end

    // reset while a request is outstanding
    send_byte(8'h52, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    wait_req(ok);
    chk("pre_reset_req", ok, 1'b1);
    #23;
    rst = 1'b0;
    #1;
    chk("reset_req_async", bus.req, 1'b0);
    chk("reset_tx_high", uart_tx, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    ra = ADDR_W'($urandom);
    rd = DATA_W'($urandom);
    do_txn(1'b0, ra, rd, 1);

`ifdef UART_BRIDGE_TIMEOUT_EN
    begin
      int t0, n;
      t0 = to_pulses;
      n  = 0;
      send_byte(8'h57, 1'b1);
      send_byte(8'h12, 1'b1);
      while (to_pulses == t0 && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
      chk("timeout_pulse", to_pulses - t0, 1);
      chk("timeout_near_limit", (n > 800) && (n < 1100), 1'b1);
      chk("timeout_no_req", bus.req, 1'b0);
      do_txn(1'b1, 16'h1234, 32'h5555_AAAA, 3);
    end
`else
    chk("timeout_never", to_pulses, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
